// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues operation commands to an external 8-bit combinational ALU.
// Holds a small operand register file, drives the ALU operand and opcode registers,
// captures the result and flags, writes back, and returns a response over valid/ready.
module alu_op_sequencer #(
    parameter int REG_ADDR_W = 2
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic [3:0]            CmdAluOp,
    input  logic                  CmdLoad,
    input  logic                  CmdUseImm,
    input  logic [REG_ADDR_W-1:0] CmdSrcA,
    input  logic [REG_ADDR_W-1:0] CmdSrcB,
    input  logic [REG_ADDR_W-1:0] CmdDst,
    input  logic [7:0]            CmdImm,
    output logic [7:0]            AluA,
    output logic [7:0]            AluB,
    output logic [3:0]            AluOp,
    input  logic [7:0]            AluResult,
    input  logic                  AluZero,
    input  logic                  AluNegative,
    input  logic                  AluOverflow,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [7:0]            RspResult,
    output logic [2:0]            RspFlags,
    output logic [2:0]            Flags
);

    localparam int NREG = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;

    logic [7:0] regs [NREG];

    // Command fields captured at the accept edge
    logic [3:0]            op_p0;
    logic                  load_p0;
    logic                  use_imm_p0;
    logic [REG_ADDR_W-1:0] src_a_p0;
    logic [REG_ADDR_W-1:0] src_b_p0;
    logic [REG_ADDR_W-1:0] dst_p0;
    logic [7:0]            imm_p0;

    logic       cmd_accept;
    logic [2:0] alu_flags;

    assign cmd_accept = (state == IDLE) && CmdValid && CmdReady;
    assign alu_flags  = {AluOverflow, AluNegative, AluZero};

    // Flags reported for a load: never overflow, sign bit, zero test
    function automatic logic [2:0] load_flags(input logic [7:0] value);
        logic signed [7:0] sval;
        sval = value;
        return {1'b0, (sval < 0), (value == 8'h00)};
    endfunction

    // A load of immediate zero doubles as the sticky-flags clear command
    function automatic logic is_flag_clear(input logic ld, input logic use_imm,
                                           input logic [7:0] imm);
        return ld && use_imm && (imm == 8'h00);
    endfunction

    // Latch the command fields on the handshake edge (data only, no reset needed)
    always_ff @(posedge Clk) begin
        if (cmd_accept) begin
            op_p0      <= CmdAluOp;
            load_p0    <= CmdLoad;
            use_imm_p0 <= CmdUseImm;
            src_a_p0   <= CmdSrcA;
            src_b_p0   <= CmdSrcB;
            dst_p0     <= CmdDst;
            imm_p0     <= CmdImm;
        end
    end

    // Sequencer FSM with registered outputs, register file write-back and flags
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            CmdReady  <= 1'b0;
            RspValid  <= 1'b0;
            AluA      <= '0;
            AluB      <= '0;
            AluOp     <= '0;
            RspResult <= '0;
            RspFlags  <= '0;
            Flags     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    CmdReady <= 1'b1;
                    if (cmd_accept) begin
                        CmdReady <= 1'b0;
                        // Loads need no ALU; the operand registers keep their values
                        state    <= CmdLoad ? CAPTURE : ISSUE;
                    end
                end

                ISSUE: begin
                    // Operands are read here, before write-back, so Dst==Src sees the old value
                    AluA  <= regs[src_a_p0];
                    AluB  <= use_imm_p0 ? imm_p0 : regs[src_b_p0];
                    AluOp <= op_p0;
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    if (load_p0) begin
                        regs[dst_p0] <= imm_p0;
                        RspResult    <= imm_p0;
                        RspFlags     <= load_flags(imm_p0);
                        if (is_flag_clear(load_p0, use_imm_p0, imm_p0)) begin
                            Flags <= '0;
                        end
                    end else begin
                        regs[dst_p0] <= AluResult;
                        RspResult    <= AluResult;
                        RspFlags     <= alu_flags;
                        Flags        <= Flags | alu_flags;
                    end
                    RspValid <= 1'b1;
                    state    <= RESP;
                end

                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        CmdReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed commands against a small behavioural ALU.
module tb_alu_op_sequencer;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       CmdValid;
    logic       CmdReady;
    logic [3:0] CmdAluOp;
    logic       CmdLoad;
    logic       CmdUseImm;
    logic [1:0] CmdSrcA;
    logic [1:0] CmdSrcB;
    logic [1:0] CmdDst;
    logic [7:0] CmdImm;
    logic [7:0] AluA;
    logic [7:0] AluB;
    logic [3:0] AluOp;
    logic [7:0] AluResult;
    logic       AluZero;
    logic       AluNegative;
    logic       AluOverflow;
    logic       RspValid;
    logic       RspReady;
    logic [7:0] RspResult;
    logic [2:0] RspFlags;
    logic [2:0] Flags;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.REG_ADDR_W(2)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .CmdValid    (CmdValid),
        .CmdReady    (CmdReady),
        .CmdAluOp    (CmdAluOp),
        .CmdLoad     (CmdLoad),
        .CmdUseImm   (CmdUseImm),
        .CmdSrcA     (CmdSrcA),
        .CmdSrcB     (CmdSrcB),
        .CmdDst      (CmdDst),
        .CmdImm      (CmdImm),
        .AluA        (AluA),
        .AluB        (AluB),
        .AluOp       (AluOp),
        .AluResult   (AluResult),
        .AluZero     (AluZero),
        .AluNegative (AluNegative),
        .AluOverflow (AluOverflow),
        .RspValid    (RspValid),
        .RspReady    (RspReady),
        .RspResult   (RspResult),
        .RspFlags    (RspFlags),
        .Flags       (Flags)
    );

    // External ALU: op 0 = add, op 1 = subtract, others pass A
    always_comb begin
        AluResult   = AluA;
        AluOverflow = 1'b0;
        case (AluOp)
            4'd0: begin
                AluResult   = AluA + AluB;
                AluOverflow = (AluA[7] == AluB[7]) && (AluResult[7] != AluA[7]);
            end
            4'd1: begin
                AluResult   = AluA - AluB;
                AluOverflow = (AluA[7] != AluB[7]) && (AluResult[7] != AluA[7]);
            end
            default: ;
        endcase
        AluZero     = (AluResult == 8'h00);
        AluNegative = AluResult[7];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command, wait for accept, then count edges until RspValid
    task automatic send(input logic ld, input logic ui, input logic [3:0] op,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                        input logic [7:0] imm, output int lat);
        int n;
        CmdLoad = ld; CmdUseImm = ui; CmdAluOp = op;
        CmdSrcA = sa; CmdSrcB = sb; CmdDst = d; CmdImm = imm;
        CmdValid = 1'b1;
        n = 0;
        while (!CmdReady && n < 20) begin
            @(posedge Clk); #1; n++;
        end
        if (!CmdReady) chk("cmd_ready_timeout", 32'(CmdReady), 32'd1);
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        lat = 1;
        while (!RspValid && lat < 20) begin
            @(posedge Clk); #1; lat++;
        end
    endtask

    task automatic finish_rsp();
        RspReady = 1'b1;
        @(posedge Clk); #1;
        RspReady = 1'b0;
    endtask

    // Full command with response checks; ALU operands checked for non-load commands
    task automatic run(input string tag, input logic ld, input logic ui, input logic [3:0] op,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                       input logic [7:0] imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                       input logic [7:0] exp_res, input logic [2:0] exp_rf,
                       input logic [2:0] exp_flags);
        int lat;
        send(ld, ui, op, sa, sb, d, imm, lat);
        chk({tag, "_lat"}, 32'(lat), ld ? 32'd2 : 32'd3);
        if (!ld) begin
            chk({tag, "_alu_a"}, 32'(AluA), 32'(exp_a));
            chk({tag, "_alu_b"}, 32'(AluB), 32'(exp_b));
        end
        chk({tag, "_result"}, 32'(RspResult), 32'(exp_res));
        chk({tag, "_rsp_flags"}, 32'(RspFlags), 32'(exp_rf));
        chk({tag, "_flags"}, 32'(Flags), 32'(exp_flags));
        finish_rsp();
    endtask

    initial begin
        int lat;
        Rst_n = 1'b0; CmdValid = 1'b0; RspReady = 1'b0;
        CmdAluOp = '0; CmdLoad = 1'b0; CmdUseImm = 1'b0;
        CmdSrcA = '0; CmdSrcB = '0; CmdDst = '0; CmdImm = '0;

        // Reset state
        #12;
        chk("rst_cmd_ready", 32'(CmdReady), 32'd0);
        chk("rst_rsp_valid", 32'(RspValid), 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        chk("rst_alu_a", 32'(AluA), 32'd0);
        chk("rst_alu_op", 32'(AluOp), 32'd0);
        chk("rst_rsp_result", 32'(RspResult), 32'd0);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("idle_cmd_ready", 32'(CmdReady), 32'd1);

        // Loads, then 7F + 01 -> r2 overflows into the sign bit
        run("ld_r0", 1, 0, 4'd0, 0, 0, 0, 8'h7F, 0, 0, 8'h7F, 3'b000, 3'b000);
        run("ld_r1", 1, 0, 4'd0, 0, 0, 1, 8'h01, 0, 0, 8'h01, 3'b000, 3'b000);
        run("add_ovf", 0, 0, 4'd0, 0, 1, 2, 8'h00, 8'h7F, 8'h01, 8'h80, 3'b110, 3'b110);

        // Load zero without UseImm: zero flag reported, sticky flags untouched
        run("ld_r3_zero", 1, 0, 4'd0, 0, 0, 3, 8'h00, 0, 0, 8'h00, 3'b001, 3'b110);

        // Back-pressure: response held, no new command accepted
        send(1, 0, 4'd0, 0, 0, 0, 8'h05, lat);
        chk("hold_lat", 32'(lat), 32'd2);
        CmdLoad = 1'b1; CmdImm = 8'hAA; CmdDst = 2'd1; CmdValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            chk("hold_result", 32'(RspResult), 32'h05);
            chk("hold_cmd_ready", 32'(CmdReady), 32'd0);
            chk("hold_rsp_valid", 32'(RspValid), 32'd1);
        end
        chk("hold_rsp_flags", 32'(RspFlags), 32'd0);
        CmdValid = 1'b0;
        finish_rsp();
        chk("release_rsp_valid", 32'(RspValid), 32'd0);
        chk("release_cmd_ready", 32'(CmdReady), 32'd1);

        // Dst == SrcA: old operand read, result written back
        run("add_imm_r0", 0, 1, 4'd0, 0, 0, 0, 8'h03, 8'h05, 8'h03, 8'h08, 3'b000, 3'b110);
        run("read_r0", 0, 1, 4'd0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 8'h08, 3'b000, 3'b110);
        run("read_r2", 0, 1, 4'd0, 2, 0, 2, 8'h00, 8'h80, 8'h00, 8'h80, 3'b010, 3'b110);

        // Flags clear after the earlier overflow
        run("flag_clear", 1, 1, 4'd0, 0, 0, 3, 8'h00, 0, 0, 8'h00, 3'b001, 3'b000);

        // Subtract to zero sets only the zero flag
        run("sub_zero", 0, 1, 4'd1, 0, 0, 1, 8'h08, 8'h08, 8'h08, 8'h00, 3'b001, 3'b001);
        run("read_r1", 0, 1, 4'd1, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001);
        chk("sub_alu_op", 32'(AluOp), 32'd1);

        // Reset asserted during CAPTURE of 08 + 01 -> r1 aborts the command
        CmdLoad = 1'b0; CmdUseImm = 1'b1; CmdAluOp = 4'd0;
        CmdSrcA = 2'd0; CmdSrcB = 2'd0; CmdDst = 2'd1; CmdImm = 8'h01;
        CmdValid = 1'b1;
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        @(posedge Clk); #1;
        chk("abort_alu_a_pre", 32'(AluA), 32'h08);
        Rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(RspValid), 32'd0);
        chk("abort_flags", 32'(Flags), 32'd0);
        chk("abort_cmd_ready", 32'(CmdReady), 32'd0);
        chk("abort_alu_a", 32'(AluA), 32'd0);
        #3;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("abort_idle_ready", 32'(CmdReady), 32'd1);
        chk("abort_no_rsp", 32'(RspValid), 32'd0);
        run("read_r1_rst", 0, 1, 4'd0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001);
        run("read_r0_rst", 0, 1, 4'd0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Issuing side of the 8-bit ALU interface: accepts operation commands over a valid/ready handshake.
- Holds a small operand register file and drives A, B and AluOp to an external 8-bit ALU instance.
- Samples the ALU's Result and its Zero/Negative/Overflow flags, writes the result back, updates a flags register and returns a response.
- Sits between the instruction/control path and the combinational ALU.

Parameters:
- REG_ADDR_W, 2, register-file address width; register count = 2**REG_ADDR_W, each register 8 bits.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- CmdValid  in  1  command present
- CmdReady  out  1  sequencer can accept a command
- CmdAluOp  in  4  ALU operation code, passed unchanged to AluOp
- CmdLoad  in  1  1 = load CmdImm into CmdDst (no ALU op); 0 = ALU op
- CmdUseImm  in  1  1 = B operand is CmdImm; 0 = B operand is reg[CmdSrcB]
- CmdSrcA  in  REG_ADDR_W  A operand register
- CmdSrcB  in  REG_ADDR_W  B operand register
- CmdDst  in  REG_ADDR_W  destination register
- CmdImm  in  8  immediate value
- AluA  out  8  ALU operand A
- AluB  out  8  ALU operand B
- AluOp  out  4  ALU operation select
- AluResult  in  8  ALU result
- AluZero  in  1  ALU zero flag
- AluNegative  in  1  ALU negative flag
- AluOverflow  in  1  ALU signed-overflow flag
- RspValid  out  1  response present
- RspReady  in  1  consumer accepts response
- RspResult  out  8  value written to destination
- RspFlags  out  3  {Overflow, Negative, Zero} for this command
- Flags  out  3  sticky flags register {Overflow, Negative, Zero}

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE; all registers, Flags, AluA, AluB, AluOp, RspResult and RspFlags = 0.
  - RspValid=0, CmdReady=0 while reset is asserted.
  - Reset asserted mid-operation aborts the command: no write-back, no response.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - CmdReady=1. Handshake completes on a rising edge with CmdValid&CmdReady.
  - On accept, latch the command fields and go to ISSUE.
- ISSUE (1 cycle):
  - AluA <= reg[SrcA]; AluB <= UseImm ? Imm : reg[SrcB]; AluOp <= CmdAluOp. These are registered outputs, stable through CAPTURE.
  - Go to CAPTURE.
  - Load commands skip ISSUE: IDLE -> CAPTURE directly, and the ALU outputs hold their previous values.
- CAPTURE (1 cycle), go to RESP:
  - ALU op: sample AluResult and the three flags; reg[Dst] <= AluResult; RspResult <= AluResult; RspFlags <= sampled flags; Flags <= Flags | sampled flags.
  - Load: reg[Dst] <= Imm; RspResult <= Imm; RspFlags <= {1'b0, Imm[7], Imm==0}; Flags unchanged.
- RESP:
  - RspValid=1; RspResult and RspFlags held stable until RspValid&RspReady.
  - On that edge go to IDLE with RspValid=0.
  - CmdReady=0 throughout ISSUE, CAPTURE and RESP.
- Latency, accept edge to RspValid high:
  - ALU op: 3 edges (accept, ISSUE, CAPTURE).
  - Load: 2 edges.
- Throughput: 1 command per 4 cycles for ALU ops at best (RspReady held high); the next accept is possible the cycle after the response handshake.
- Register hazards:
  - Dst may equal SrcA and/or SrcB: operands are read in ISSUE, before write-back in CAPTURE, so the old value is used.
  - A later command sees the written value (no bypass needed; commands are serialised).
- Flags register clear:
  - A command with CmdLoad=1, CmdUseImm=1 and CmdImm=8'h00 also clears Flags to 0 in CAPTURE.
  - This clear takes priority over sticky accumulation.
- Out-of-range values: none. All REG_ADDR_W codes are valid; CmdAluOp values are passed through unchecked.

Test Plan:
- Reset then load r0=8'h7F, r1=8'h01, then op 4'b0000 (add), A=r0, B=r1, Dst=r2 -> AluA=7F, AluB=01 in CAPTURE; with a real ALU, RspResult=8'h80, RspFlags=3'b110, Flags=3'b110, r2=80.
- Load immediate 8'h00 to r3 (UseImm=0) -> RspResult=00, RspFlags=3'b001, Flags unchanged; RspValid rises exactly 2 edges after accept.
- Hold RspReady=0 for 5 cycles after RspValid -> RspResult/RspFlags stable, CmdReady=0, a new CmdValid is not accepted; RspReady=1 -> IDLE next cycle, CmdReady=1.
- Op with Dst=SrcA=r0 (r0=05), UseImm=1, Imm=03, op add -> AluA=05, AluB=03, r0=08 afterward.
- Assert Rst_n=0 during CAPTURE of an ALU op targeting r1 -> r1=0, RspValid=0, Flags=0 immediately (async), state IDLE after release.
- Flags-clear command (CmdLoad=1, CmdUseImm=1, CmdImm=00) after an overflow -> Flags=3'b000.
